// File: rtl/transpose_tile_loader.sv
// ---------------------------------------------------------------------------
// transpose_tile_loader
//
// Upstream feeder for the transpose switch network. Collects NUM_PE rows of
// NUM_PE chunks from a valid/ready stream into a tile bank, then presents the
// whole NUM_PE x NUM_PE tile with a one-cycle valid pulse and the transpose
// control sampled on the tile's first row. A row flagged with row_last ends
// the tile early; unwritten rows are presented as zero.
//
// Optional feature: define TILE_LOADER_PINGPONG_EN for two banks and no
// issue bubble (1 row/cycle sustained). Default build uses one bank and
// deasserts row_rdy for the single issue cycle.
//
// Ports:
//   clk            in   clock, all logic on posedge
//   rst            in   synchronous reset, active-high
//   row_in         in   one tile row, chunk k at index k
//   row_val        in   row_in valid
//   row_rdy        out  a row can be accepted this cycle
//   row_last       in   accepted row is the final row of a short tile
//   mode_transpose in   transpose request, sampled on row 0 of each tile
//   tile_elements  out  assembled tile [row][chunk], held until next issue
//   tile_val       out  one-cycle pulse, tile_elements valid
//   tile_ctrl      out  transpose control for the presented tile
//   busy           out  partial tile held or issue in progress
// ---------------------------------------------------------------------------
module transpose_tile_loader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned NUM_MG     = 8,
    parameter int unsigned NUM_PE     = NUM_MG,
    localparam int unsigned CHUNK_WIDTH = NUM_MG / NUM_PE * DATA_WIDTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]            row_in,
    input  logic                                          row_val,
    output logic                                          row_rdy,
    input  logic                                          row_last,
    input  logic                                          mode_transpose,
    output logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] tile_elements,
    output logic                                          tile_val,
    output logic                                          tile_ctrl,
    output logic                                          busy
);

`ifdef TILE_LOADER_PINGPONG_EN
    localparam int unsigned NumBanks = 2;
`else
    localparam int unsigned NumBanks = 1;
`endif
    localparam int unsigned RowW    = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int unsigned NumRows = NumBanks * NUM_PE;
    localparam int unsigned AddrW   = (NumRows > 1) ? $clog2(NumRows) : 1;

    typedef enum logic [0:0] {StFill, StIssue} state_e;

    state_e                                        state_q, state_d;
    logic [RowW-1:0]                               wr_row_q, wr_row_d;
    logic [NumRows-1:0]                            mask_q, mask_d;
    logic                                          pend_ctrl_q, pend_ctrl_d;
    logic [0:NUM_PE-1][0:NUM_PE-1][CHUNK_WIDTH-1:0] tile_q, tile_d;
    logic                                          tile_ctrl_q, tile_ctrl_d;
    logic                                          tile_val_q, tile_val_d;

    // Bank rows are flat-addressed as {bank, row}; contents are never reset,
    // validity is tracked by mask_q.
    logic [0:NUM_PE-1][CHUNK_WIDTH-1:0]            bank_q [NumRows];

    logic [AddrW-1:0] base_addr;
    logic [AddrW-1:0] wr_addr;
    logic             accept;
    logic             last_row;
    logic             finish;

`ifdef TILE_LOADER_PINGPONG_EN
    logic bank_sel_q, bank_sel_d;

    // Filling continues into the other bank during the issue cycle.
    assign row_rdy    = ~rst;
    assign base_addr  = bank_sel_q ? AddrW'(NUM_PE) : '0;
    assign bank_sel_d = finish ? ~bank_sel_q : bank_sel_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            bank_sel_q <= 1'b0;
        end else begin
            bank_sel_q <= bank_sel_d;
        end
    end
`else
    assign row_rdy   = ~rst & (state_q == StFill);
    assign base_addr = '0;
`endif

    assign wr_addr  = base_addr + AddrW'(wr_row_q);
    assign accept   = row_val & row_rdy;
    assign last_row = (wr_row_q == RowW'(NUM_PE - 1)) | row_last;
    assign finish   = accept & last_row;

    always_comb begin
        state_d     = finish ? StIssue : StFill;
        wr_row_d    = wr_row_q;
        mask_d      = mask_q;
        pend_ctrl_d = pend_ctrl_q;
        tile_d      = tile_q;
        tile_ctrl_d = tile_ctrl_q;
        tile_val_d  = finish;

        if (accept) begin
            if (wr_row_q == '0) begin
                pend_ctrl_d = mode_transpose;
            end
            wr_row_d        = wr_row_q + 1'b1;
            mask_d[wr_addr] = 1'b1;
        end

        if (finish) begin
            wr_row_d = '0;
            // The final row bypasses the bank so the tile is captured on the
            // accepting edge and tile_val follows one cycle later.
            for (int unsigned r = 0; r < NUM_PE; r++) begin
                if (RowW'(r) == wr_row_q) begin
                    tile_d[RowW'(r)] = row_in;
                end else if (mask_q[base_addr + AddrW'(r)]) begin
                    tile_d[RowW'(r)] = bank_q[base_addr + AddrW'(r)];
                end else begin
                    tile_d[RowW'(r)] = '0;
                end
                mask_d[base_addr + AddrW'(r)] = 1'b0;
            end
            // A one-row tile has not yet latched its mode.
            tile_ctrl_d = (wr_row_q == '0) ? mode_transpose : pend_ctrl_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StFill;
            wr_row_q    <= '0;
            mask_q      <= '0;
            pend_ctrl_q <= 1'b0;
            tile_q      <= '0;
            tile_ctrl_q <= 1'b0;
            tile_val_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_row_q    <= wr_row_d;
            mask_q      <= mask_d;
            pend_ctrl_q <= pend_ctrl_d;
            tile_q      <= tile_d;
            tile_ctrl_q <= tile_ctrl_d;
            tile_val_q  <= tile_val_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            bank_q[wr_addr] <= row_in;
        end
    end

    assign tile_elements = tile_q;
    assign tile_ctrl     = tile_ctrl_q;
    // Reset during the issue cycle suppresses the pulse immediately.
    assign tile_val      = tile_val_q & ~rst;
    assign busy          = (wr_row_q != '0) | (state_q == StIssue);

endmodule

// File: tb/tb_transpose_tile_loader.sv
module tb_transpose_tile_loader;

    localparam int unsigned NPE = 8;

`ifdef TILE_LOADER_PINGPONG_EN
    localparam int ExpRdyLow = 0;
`else
    localparam int ExpRdyLow = 1;
`endif

    logic                       clk = 1'b0;
    logic                       rst;
    logic [0:NPE-1][63:0]       row_in;
    logic                       row_val;
    logic                       row_rdy;
    logic                       row_last;
    logic                       mode_transpose;
    logic [0:NPE-1][0:NPE-1][63:0] tile_elements;
    logic                       tile_val;
    logic                       tile_ctrl;
    logic                       busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic hold_ctrl = 1'b0;

    transpose_tile_loader dut (
        .clk            (clk),
        .rst            (rst),
        .row_in         (row_in),
        .row_val        (row_val),
        .row_rdy        (row_rdy),
        .row_last       (row_last),
        .mode_transpose (mode_transpose),
        .tile_elements  (tile_elements),
        .tile_val       (tile_val),
        .tile_ctrl      (tile_ctrl),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned nrows;
        logic        last;
        logic        stall;
        logic        mode0;
        logic        mode_rest;
        int unsigned id;
        logic        exp_ctrl;
        int unsigned exp_rows;
    } tile_vec_t;

    tile_vec_t vecs [8];

    function automatic logic [0:NPE-1][63:0] make_row(input int unsigned id,
                                                      input int unsigned r);
        logic [0:NPE-1][63:0] v;
        for (int k = 0; k < NPE; k++) v[k] = 64'(id * 256 + r * 16 + k);
        return v;
    endfunction

    task automatic check(input string name, input logic [511:0] act,
                         input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_tile(input string name, input int unsigned id,
                              input int unsigned rows);
        logic [0:NPE-1][63:0] exp_row;
        for (int r = 0; r < NPE; r++) begin
            exp_row = (r < rows) ? make_row(id, r) : '0;
            check($sformatf("%s row%0d", name, r), tile_elements[r], exp_row);
        end
    endtask

    // Streams one tile, then watches a few idle cycles for its pulse.
    task automatic run_tile(input tile_vec_t v, input string name);
        int unsigned sent = 0;
        int guard = 0, phase = 0, early = 0, pulses = 0, pulse_at = -1, rdy_low = 0;
        logic hold_checked = 1'b0;
        while (sent < v.nrows && guard < 200) begin
            @(posedge clk); #1;
            guard++;
            row_val        = !v.stall || (phase % 3 == 0);
            phase++;
            row_in         = make_row(v.id, sent);
            // On stall cycles row_last is raised without row_val; it must be ignored.
            row_last       = row_val ? (v.last && sent == v.nrows - 1) : v.stall;
            mode_transpose = (sent == 0) ? v.mode0 : v.mode_rest;
            @(negedge clk);
            if (tile_val) early++;
            if (!hold_checked) begin
                check({name, " ctrl hold"}, tile_ctrl, hold_ctrl);
                hold_checked = 1'b1;
            end
            if (row_val && row_rdy) sent++;
        end
        check({name, " rows accepted"}, sent, v.nrows);
        check({name, " no early tile_val"}, early, 0);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk); #1;
            row_val  = 1'b0;
            row_last = 1'b0;
            @(negedge clk);
            if (tile_val) begin
                pulses++;
                if (pulse_at < 0) pulse_at = i;
            end
            if (!row_rdy) rdy_low++;
        end
        check({name, " pulse count"}, pulses, 1);
        check({name, " pulse latency"}, pulse_at, 1);
        check({name, " rdy low cycles"}, rdy_low, ExpRdyLow);
        check({name, " ctrl"}, tile_ctrl, v.exp_ctrl);
        check_tile(name, v.id, v.exp_rows);
        hold_ctrl = v.exp_ctrl;
    endtask

    initial begin
        //           nrows last stall m0 mrest id ctrl rows
        vecs[0] = '{8, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b1, 8};  // full tile
        vecs[1] = '{3, 1'b1, 1'b0, 1'b1, 1'b1, 2, 1'b1, 3};  // short tile
        vecs[2] = '{8, 1'b0, 1'b0, 1'b0, 1'b0, 3, 1'b0, 8};  // no residue
        vecs[3] = '{8, 1'b0, 1'b1, 1'b1, 1'b0, 4, 1'b1, 8};  // source stalls
        vecs[4] = '{8, 1'b0, 1'b0, 1'b1, 1'b0, 5, 1'b1, 8};  // mode on row 0 only
        vecs[5] = '{8, 1'b0, 1'b0, 1'b0, 1'b1, 6, 1'b0, 8};  // mode 0 on row 0
        vecs[6] = '{1, 1'b1, 1'b0, 1'b1, 1'b1, 7, 1'b1, 1};  // last on first row
        vecs[7] = '{8, 1'b1, 1'b0, 1'b0, 1'b0, 8, 1'b0, 8};  // last on row 7

        rst = 1'b1; row_val = 1'b0; row_last = 1'b0; mode_transpose = 1'b0; row_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rdy during reset", row_rdy, 1'b0);
        check("tile_val during reset", tile_val, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset busy", busy, 1'b0);
        check("reset ctrl", tile_ctrl, 1'b0);
        check("reset tile_val", tile_val, 1'b0);
        check("reset rdy", row_rdy, 1'b1);
        check_tile("reset tile", 0, 0);

        for (int i = 0; i < 8; i++) run_tile(vecs[i], $sformatf("vec%0d", i));

        // Reset in the middle of a fill discards the partial tile.
        for (int r = 0; r < 5; r++) begin
            @(posedge clk); #1;
            row_val = 1'b1; row_last = 1'b0; mode_transpose = 1'b1;
            row_in  = make_row(9, r);
        end
        @(posedge clk); #1;
        row_val = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        check("partial busy", busy, 1'b1);
        check("midfill rdy in reset", row_rdy, 1'b0);
        check("midfill tile_val", tile_val, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post reset busy", busy, 1'b0);
        check("post reset tile_val", tile_val, 1'b0);
        check("post reset ctrl", tile_ctrl, 1'b0);
        check_tile("post reset tile", 0, 0);
        hold_ctrl = 1'b0;
        run_tile('{8, 1'b0, 1'b0, 1'b0, 1'b0, 10, 1'b0, 8}, "after reset");

`ifdef TILE_LOADER_PINGPONG_EN
        begin
            int unsigned sent = 0;
            int drops = 0, npulse = 0;
            int pcyc [3] = '{-1, -1, -1};
            for (int c = 0; c < 30; c++) begin
                @(posedge clk); #1;
                row_last = 1'b0;
                if (sent < 24) begin
                    row_val        = 1'b1;
                    row_in         = make_row(20 + sent / 8, sent % 8);
                    mode_transpose = (sent % 8 == 0) ? 1'((sent / 8) % 2) : 1'b0;
                end else begin
                    row_val = 1'b0;
                end
                @(negedge clk);
                if (tile_val) begin
                    if (npulse < 3) begin
                        pcyc[npulse] = c;
                        check_tile($sformatf("pp tile%0d", npulse), 20 + npulse, 8);
                        check($sformatf("pp ctrl%0d", npulse), tile_ctrl, 1'(npulse % 2));
                    end
                    npulse++;
                end
                if (!row_rdy) drops++;
                if (row_val && row_rdy) sent++;
            end
            check("pp rdy drops", drops, 0);
            check("pp pulses", npulse, 3);
            check("pp first pulse", pcyc[0], 8);
            check("pp spacing 1", pcyc[1] - pcyc[0], 8);
            check("pp spacing 2", pcyc[2] - pcyc[1], 8);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
